contour_window_filter: RTL and testbench

Parametrised streaming 3x3 morphological and contour filter for the video pipeline between edge detection and the VGA output stage.
- Binarises incoming pixels against a threshold and builds a true 2-D 3x3 window from two 1-bit line buffers.
- Applies a run-time selectable mode: contour, boundary, dilate or erode.
- Emits one full-intensity or black pixel per input pixel.
- Handles frame borders with zero padding and self-flushes the last row through an internal FLUSH state.

---
 rtl/contour_window_filter_if.sv | 25 ++
 rtl/contour_window_filter.sv | 181 ++++++++++++++++++
 tb/tb_contour_window_filter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/contour_window_filter_if.sv
// Stream interface of the 3x3 contour/morphology filter: pixel input handshake,
// frame mode select and the unthrottled binary pixel output.
interface contour_window_filter_if #(
    parameter int PIX_W = 8
);
    logic [1:0]       mode;
    logic             in_valid;
    logic             in_ready;
    logic             in_sof;
    logic [PIX_W-1:0] in_pix;
    logic             out_valid;
    logic             out_sof;
    logic [PIX_W-1:0] out_pix;
    logic             frame_done;

    modport master (
        output mode, in_valid, in_sof, in_pix,
        input  in_ready, out_valid, out_sof, out_pix, frame_done
    );

    modport slave (
        input  mode, in_valid, in_sof, in_pix,
        output in_ready, out_valid, out_sof, out_pix, frame_done
    );
endinterface

// File: rtl/contour_window_filter.sv
// Streaming 3x3 binary morphology/contour filter: binarises pixels, forms a zero-padded
// 3x3 window from a 2-line bit history and emits one black/white pixel per input pixel.
module contour_window_filter #(
    parameter int PIX_W      = 8,
    parameter int LINE_W     = 640,
    parameter int FRAME_H    = 480,
    parameter int BIN_THRESH = 0,
    parameter int MIN_COUNT  = 5
) (
    input logic                    VGA_CLK,
    input logic                    RST,
    contour_window_filter_if.slave bus
);
    localparam int COL_W  = $clog2(LINE_W);
    localparam int ROW_W  = $clog2(FRAME_H);
    localparam int FILL_W = $clog2(LINE_W + 2);
    localparam int SR_W   = 2 * LINE_W + 3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;
    typedef enum logic [1:0] {M_CONTOUR, M_BOUNDARY, M_DILATE, M_ERODE} mode_t;

    state_t            state_q, state_d;
    mode_t             mode_q, mode_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [ROW_W-1:0]  wr_row_q, wr_row_d, ctr_row_q, ctr_row_d;
    logic [COL_W-1:0]  wr_col_q, wr_col_d, ctr_col_q, ctr_col_d;
    logic [FILL_W-1:0] fill_q, fill_d, flush_q, flush_d;
    logic              out_valid_q, out_valid_d, out_sof_q, out_sof_d;
    logic [PIX_W-1:0]  out_pix_q, out_pix_d;
    logic              done_pend_q, done_pend_d, frame_done_q, frame_done_d;

    logic              in_ready, accept, start, beat, new_bit, emit, last_pix, last_flush;
    logic [2:0][2:0]   win;
    logic [3:0]        set_count;
    logic [3:0]        n4;
    logic              decision;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        sr_d         = sr_q;
        wr_row_d     = wr_row_q;
        wr_col_d     = wr_col_q;
        ctr_row_d    = ctr_row_q;
        ctr_col_d    = ctr_col_q;
        fill_d       = fill_q;
        flush_d      = flush_q;
        out_valid_d  = 1'b0;
        out_sof_d    = 1'b0;
        out_pix_d    = '0;
        done_pend_d  = 1'b0;
        frame_done_d = done_pend_q;

        in_ready   = (state_q != S_FLUSH);
        accept     = bus.in_valid & in_ready;
        start      = accept & bus.in_sof;
        beat       = start | (accept & (state_q == S_RUN)) | (state_q == S_FLUSH);
        new_bit    = (state_q != S_FLUSH) && (bus.in_pix > PIX_W'(BIN_THRESH));
        emit       = beat & ~start & (fill_q == FILL_W'(LINE_W + 1));
        last_pix   = (wr_row_q == ROW_W'(FRAME_H - 1)) && (wr_col_q == COL_W'(LINE_W - 1));
        last_flush = (state_q == S_FLUSH) && (flush_q == FILL_W'(LINE_W));

        // sr_d[0] is the newest beat; the centre sits LINE_W+1 beats behind it
        if (beat) begin
            sr_d = {sr_q[SR_W-2:0], new_bit};
        end
        win[0] = {sr_d[2*LINE_W],   sr_d[2*LINE_W+1], sr_d[2*LINE_W+2]};
        win[1] = {sr_d[LINE_W],     sr_d[LINE_W+1],   sr_d[LINE_W+2]};
        win[2] = {sr_d[0],          sr_d[1],          sr_d[2]};
        if (ctr_row_q == '0) begin
            win[0] = '0;
        end
        if (ctr_row_q == ROW_W'(FRAME_H - 1)) begin
            win[2] = '0;
        end
        if (ctr_col_q == '0) begin
            win[0][0] = 1'b0;
            win[1][0] = 1'b0;
            win[2][0] = 1'b0;
        end
        if (ctr_col_q == COL_W'(LINE_W - 1)) begin
            win[0][2] = 1'b0;
            win[1][2] = 1'b0;
            win[2][2] = 1'b0;
        end

        set_count = 4'($countones(win));
        n4        = {win[0][1], win[2][1], win[1][0], win[1][2]};
        case (mode_q)
            M_CONTOUR:  decision = win[1][1] && (set_count >= 4'(MIN_COUNT)) && (|n4);
            M_BOUNDARY: decision = win[1][1] && !(&n4);
            M_DILATE:   decision = |win;
            M_ERODE:    decision = &win;
            default:    decision = 1'b0;
        endcase

        if (start) begin
            state_d   = S_RUN;
            mode_d    = mode_t'(bus.mode);
            wr_row_d  = '0;
            wr_col_d  = COL_W'(1);
            ctr_row_d = '0;
            ctr_col_d = '0;
            fill_d    = FILL_W'(1);
        end else if (beat) begin
            if (fill_q != FILL_W'(LINE_W + 1)) begin
                fill_d = fill_q + FILL_W'(1);
            end
            if (state_q == S_RUN) begin
                if (last_pix) begin
                    state_d = S_FLUSH;
                    flush_d = '0;
                end else if (wr_col_q == COL_W'(LINE_W - 1)) begin
                    wr_col_d = '0;
                    wr_row_d = wr_row_q + ROW_W'(1);
                end else begin
                    wr_col_d = wr_col_q + COL_W'(1);
                end
            end else begin
                flush_d = flush_q + FILL_W'(1);
                if (last_flush) begin
                    state_d     = S_IDLE;
                    done_pend_d = 1'b1;
                end
            end
        end

        // frame_done trails the final output by one cycle, hence the pending stage
        if (emit) begin
            out_valid_d = 1'b1;
            out_sof_d   = (ctr_row_q == '0) && (ctr_col_q == '0);
            out_pix_d   = {PIX_W{decision}};
            if (ctr_col_q == COL_W'(LINE_W - 1)) begin
                ctr_col_d = '0;
                ctr_row_d = (ctr_row_q == ROW_W'(FRAME_H - 1)) ? '0 : ctr_row_q + ROW_W'(1);
            end else begin
                ctr_col_d = ctr_col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge VGA_CLK or posedge RST) begin
        if (RST) begin
            state_q      <= S_IDLE;
            mode_q       <= M_CONTOUR;
            sr_q         <= '0;
            wr_row_q     <= '0;
            wr_col_q     <= '0;
            ctr_row_q    <= '0;
            ctr_col_q    <= '0;
            fill_q       <= '0;
            flush_q      <= '0;
            out_valid_q  <= 1'b0;
            out_sof_q    <= 1'b0;
            out_pix_q    <= '0;
            done_pend_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            sr_q         <= sr_d;
            wr_row_q     <= wr_row_d;
            wr_col_q     <= wr_col_d;
            ctr_row_q    <= ctr_row_d;
            ctr_col_q    <= ctr_col_d;
            fill_q       <= fill_d;
            flush_q      <= flush_d;
            out_valid_q  <= out_valid_d;
            out_sof_q    <= out_sof_d;
            out_pix_q    <= out_pix_d;
            done_pend_q  <= done_pend_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_sof    = out_sof_q;
    assign bus.out_pix    = out_pix_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_contour_window_filter.sv
// Bench for contour_window_filter on a 4x3 frame: hand-computed vectors, multi-cycle
// corner sequences and random frames checked against a neighbourhood-rule model.
`timescale 1ns/1ps
module tb_contour_window_filter;
    localparam int PIX_W      = 8;
    localparam int LINE_W     = 4;
    localparam int FRAME_H    = 3;
    localparam int BIN_THRESH = 0;
    localparam int MIN_COUNT  = 5;
    localparam int NPIX       = LINE_W * FRAME_H;
    localparam int NVEC       = 7;

    localparam logic [1:0] M_CONTOUR  = 2'd0;
    localparam logic [1:0] M_BOUNDARY = 2'd1;
    localparam logic [1:0] M_DILATE   = 2'd2;
    localparam logic [1:0] M_ERODE    = 2'd3;

    typedef struct {
        logic [1:0]      mode;
        logic [NPIX-1:0] pix_mask;
        logic [NPIX-1:0] exp_mask;
    } vec_t;

    logic VGA_CLK = 1'b0;
    logic RST     = 1'b1;
    always #5 VGA_CLK = ~VGA_CLK;

    contour_window_filter_if #(.PIX_W(PIX_W)) bus ();

    contour_window_filter #(
        .PIX_W(PIX_W), .LINE_W(LINE_W), .FRAME_H(FRAME_H),
        .BIN_THRESH(BIN_THRESH), .MIN_COUNT(MIN_COUNT)
    ) dut (
        .VGA_CLK(VGA_CLK),
        .RST(RST),
        .bus(bus)
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0, out_total = 0, done_total = 0, noready_total = 0;
    int sof_in_cyc = 0, sof_lat = 0, last_ov_cyc = 0, done_cyc = 0;
    logic             obs_sof [4096];
    logic [PIX_W-1:0] obs_pix [4096];
    logic [PIX_W-1:0] cur_pix [16];
    vec_t             tbl [8];

    // Monitor samples at the falling edge, when inputs for the next capture are stable
    always @(negedge VGA_CLK) begin
        cyc <= cyc + 1;
        if (!RST) begin
            if (bus.in_valid && bus.in_ready && bus.in_sof) sof_in_cyc <= cyc;
            if (!bus.in_ready) noready_total <= noready_total + 1;
            if (bus.out_valid) begin
                obs_sof[12'(out_total)] <= bus.out_sof;
                obs_pix[12'(out_total)] <= bus.out_pix;
                out_total   <= out_total + 1;
                last_ov_cyc <= cyc;
                if (bus.out_sof) sof_lat <= cyc - sof_in_cyc;
            end
            if (bus.frame_done) begin
                done_total <= done_total + 1;
                done_cyc   <= cyc;
            end
        end
    end

    function automatic logic bitAt(input logic [NPIX-1:0] v, input int k);
        return |(v & (NPIX'(1) << k));
    endfunction

    // Zero-padded 3x3 neighbourhood rules evaluated directly on the frame
    function automatic logic [NPIX-1:0] refModel(input logic [1:0] m, input logic [NPIX-1:0] b);
        logic [NPIX-1:0] res;
        res = '0;
        for (int r = 0; r < FRAME_H; r++) begin
            for (int c = 0; c < LINE_W; c++) begin
                int   cnt, n4;
                logic v, ctr, d;
                cnt = 0;
                n4  = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        v = 1'b0;
                        if (r + dr >= 0 && r + dr < FRAME_H && c + dc >= 0 && c + dc < LINE_W)
                            v = bitAt(b, (r + dr) * LINE_W + c + dc);
                        cnt += int'(v);
                        if ((dr == 0) != (dc == 0)) n4 += int'(v);
                    end
                end
                ctr = bitAt(b, r * LINE_W + c);
                case (m)
                    M_CONTOUR:  d = ctr && cnt >= MIN_COUNT && n4 > 0;
                    M_BOUNDARY: d = ctr && n4 < 4;
                    M_DILATE:   d = cnt > 0;
                    default:    d = cnt == 9;
                endcase
                if (d) res |= NPIX'(1) << (r * LINE_W + c);
            end
        end
        return res;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        vec_cnt++;
        if (actual != expected) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic loadFrame(input logic [NPIX-1:0] bits, input bit rnd_val);
        for (int k = 0; k < NPIX; k++) begin
            if (!bitAt(bits, k))  cur_pix[4'(k)] = 8'h00;
            else if (rnd_val)     cur_pix[4'(k)] = 8'($urandom_range(1, 255));
            else                  cur_pix[4'(k)] = (k % 2 == 1) ? 8'h01 : 8'hFF;
        end
    endtask

    task automatic applyStimulus(input logic [1:0] m, input int n_pix, input int gap_pct, input int junk);
        for (int j = 0; j < junk; j++) begin
            bus.in_valid = 1'b1;
            bus.in_sof   = 1'b0;
            bus.in_pix   = 8'($urandom);
            bus.mode     = 2'($urandom);
            @(posedge VGA_CLK); #1;
        end
        for (int i = 0; i < n_pix; i++) begin
            while (i > 0 && int'($urandom_range(99)) < gap_pct) begin
                bus.in_valid = 1'b0;
                bus.in_sof   = 1'b0;
                bus.in_pix   = 8'($urandom);
                bus.mode     = 2'($urandom);
                @(posedge VGA_CLK); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_sof   = (i == 0);
            bus.in_pix   = cur_pix[4'(i)];
            bus.mode     = (i == 0) ? m : 2'($urandom);
            @(posedge VGA_CLK); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_pix   = '0;
    endtask

    task automatic waitDone(input string tag, input int done_base);
        int n;
        n = 0;
        while (done_total == done_base && n < 200) begin
            @(posedge VGA_CLK); #1;
            n++;
        end
        if (done_total == done_base) checkOutput({tag, "/done_timeout"}, 0, 1);
    endtask

    task automatic checkFrame(input string tag, input logic [NPIX-1:0] exp, input int out_base,
                              input int done_base, input int nr_base, input bit check_lat);
        logic [NPIX-1:0] sofv;
        sofv = '0;
        checkOutput({tag, "/out_count"}, out_total - out_base, NPIX);
        for (int k = 0; k < NPIX; k++) begin
            checkOutput($sformatf("%s/pix%0d", tag, k), int'(obs_pix[12'(out_base + k)]),
                        bitAt(exp, k) ? 255 : 0);
            if (obs_sof[12'(out_base + k)]) sofv |= NPIX'(1) << k;
        end
        checkOutput({tag, "/sof_pattern"}, int'(sofv), 1);
        checkOutput({tag, "/frame_done_count"}, done_total - done_base, 1);
        checkOutput({tag, "/done_after_last"}, done_cyc - last_ov_cyc, 1);
        checkOutput({tag, "/flush_not_ready"}, noready_total - nr_base, LINE_W + 1);
        if (check_lat) checkOutput({tag, "/first_latency"}, sof_lat, LINE_W + 2);
    endtask

    task automatic runFrame(input string tag, input logic [1:0] m, input logic [NPIX-1:0] bits,
                            input logic [NPIX-1:0] exp, input int gap_pct, input int junk, input bit rnd_val);
        int ob, db, nb;
        loadFrame(bits, rnd_val);
        ob = out_total;
        db = done_total;
        nb = noready_total;
        applyStimulus(m, NPIX, gap_pct, junk);
        waitDone(tag, db);
        checkFrame(tag, exp, ob, db, nb, gap_pct == 0);
    endtask

    task automatic randomBits(input int density, output logic [NPIX-1:0] bits);
        bits = '0;
        for (int k = 0; k < NPIX; k++)
            if (int'($urandom_range(99)) < density) bits |= NPIX'(1) << k;
    endtask

    initial begin
        logic [NPIX-1:0] bits;
        logic [1:0]      m;
        int              ob, db, nb, gap;

        tbl[0] = '{M_DILATE,   12'h020, 12'h777};
        tbl[1] = '{M_ERODE,    12'hFFF, 12'h060};
        tbl[2] = '{M_ERODE,    12'hFBF, 12'h000};
        tbl[3] = '{M_CONTOUR,  12'h777, 12'h272};
        tbl[4] = '{M_CONTOUR,  12'h008, 12'h000};
        tbl[5] = '{M_BOUNDARY, 12'h777, 12'h757};
        tbl[6] = '{M_CONTOUR,  12'h272, 12'h020};

        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_pix   = '0;
        bus.mode     = 2'd0;
        RST          = 1'b1;
        repeat (3) @(posedge VGA_CLK);
        #1;
        checkOutput("reset/in_ready",   int'(bus.in_ready),   1);
        checkOutput("reset/out_valid",  int'(bus.out_valid),  0);
        checkOutput("reset/out_sof",    int'(bus.out_sof),    0);
        checkOutput("reset/out_pix",    int'(bus.out_pix),    0);
        checkOutput("reset/frame_done", int'(bus.frame_done), 0);
        RST = 1'b0;
        @(posedge VGA_CLK); #1;

        for (int i = 0; i < NVEC; i++)
            runFrame($sformatf("table%0d", i), tbl[3'(i)].mode, tbl[3'(i)].pix_mask,
                     tbl[3'(i)].exp_mask, 0, i % 3, 1'b0);

        // Same frame with and without input gaps must give the same result
        randomBits(50, bits);
        m = 2'($urandom);
        runFrame("nogap", m, bits, refModel(m, bits), 0, 0, 1'b1);
        runFrame("gaps",  m, bits, refModel(m, bits), 40, 0, 1'b1);

        // Abort a DILATE frame after 7 pixels with a new ERODE frame
        loadFrame(12'hFFF, 1'b1);
        ob = out_total;
        db = done_total;
        nb = noready_total;
        applyStimulus(M_DILATE, 7, 0, 0);
        applyStimulus(M_ERODE, NPIX, 0, 0);
        waitDone("abort", db);
        checkOutput("abort/partial_pix0", int'(obs_pix[12'(ob)]), 255);
        checkOutput("abort/partial_sof0", int'(obs_sof[12'(ob)]), 1);
        checkOutput("abort/partial_pix1", int'(obs_pix[12'(ob + 1)]), 255);
        checkFrame("abort", 12'h060, ob + 2, db, nb, 1'b1);

        // Reset while flushing: outputs clear at once, no frame_done follows
        randomBits(50, bits);
        loadFrame(bits, 1'b1);
        db = done_total;
        applyStimulus(M_DILATE, NPIX, 0, 0);
        @(posedge VGA_CLK); #1;
        checkOutput("flush/in_ready", int'(bus.in_ready), 0);
        checkOutput("flush/out_valid", int'(bus.out_valid), 1);
        RST = 1'b1;
        #1;
        checkOutput("rst_flush/out_valid",  int'(bus.out_valid),  0);
        checkOutput("rst_flush/out_pix",    int'(bus.out_pix),    0);
        checkOutput("rst_flush/frame_done", int'(bus.frame_done), 0);
        checkOutput("rst_flush/in_ready",   int'(bus.in_ready),   1);
        @(posedge VGA_CLK); #1;
        RST = 1'b0;
        repeat (10) @(posedge VGA_CLK);
        #1;
        checkOutput("rst_flush/no_done", done_total - db, 0);
        randomBits(50, bits);
        runFrame("after_rst", M_CONTOUR, bits, refModel(M_CONTOUR, bits), 0, 0, 1'b1);

        for (int f = 0; f < 24; f++) begin
            randomBits(int'($urandom_range(20, 85)), bits);
            m   = 2'($urandom);
            gap = (f % 2 == 0) ? 0 : 30;
            runFrame($sformatf("rand%0d", f), m, bits, refModel(m, bits), gap,
                     int'($urandom_range(0, 3)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
